// File: rtl/rf_access_arbiter_if.sv
// rf_access_arbiter_if: master-side and Register_File-side pins of rf_access_arbiter
interface rf_access_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  M0_REQ, M0_WE, M0_GNT, M0_RVALID;
    logic [ADDR_WIDTH-1:0] M0_ADDR;
    logic [DATA_WIDTH-1:0] M0_WDATA, M0_RDATA;
    logic                  M1_REQ, M1_WE, M1_GNT, M1_RVALID;
    logic [ADDR_WIDTH-1:0] M1_ADDR;
    logic [DATA_WIDTH-1:0] M1_WDATA, M1_RDATA;
    logic                  RF_RdEn, RF_WrEn, RF_RdData_Valid, RD_TIMEOUT_ERR;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData, RF_RdData;
    modport slave (
        input  M0_REQ, M0_WE, M0_ADDR, M0_WDATA, M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
        input  RF_RdData, RF_RdData_Valid,
        output M0_GNT, M0_RDATA, M0_RVALID, M1_GNT, M1_RDATA, M1_RVALID,
        output RF_RdEn, RF_WrEn, RF_Address, RF_WrData, RD_TIMEOUT_ERR
    );
    modport master (
        output M0_REQ, M0_WE, M0_ADDR, M0_WDATA, M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
        output RF_RdData, RF_RdData_Valid,
        input  M0_GNT, M0_RDATA, M0_RVALID, M1_GNT, M1_RDATA, M1_RVALID,
        input  RF_RdEn, RF_WrEn, RF_Address, RF_WrData, RD_TIMEOUT_ERR
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: two-master Register_File port arbiter; define RF_ARB_RR_EN for round-robin instead of M0-first priority
module rf_access_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 4
) (
    input logic CLK,
    input logic RST,
    rf_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;
    localparam logic [3:0] TIMEOUT = 4'(RD_TIMEOUT);
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d, err_q, err_d;
    logic                  start, win, win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    assign start = state_q == IDLE && (bus.M0_REQ || bus.M1_REQ);
`ifdef RF_ARB_RR_EN
    logic last_q, last_d;
    // on contention the master not granted last time wins
    assign win = (bus.M0_REQ && bus.M1_REQ) ? ~last_q : bus.M1_REQ;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) last_q <= 1'b1;
        else      last_q <= last_d;
    end
`else
    assign win = !bus.M0_REQ;
`endif
    assign win_we    = win ? bus.M1_WE    : bus.M0_WE;
    assign win_addr  = win ? bus.M1_ADDR  : bus.M0_ADDR;
    assign win_wdata = win ? bus.M1_WDATA : bus.M0_WDATA;
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        err_d    = 1'b0;
`ifdef RF_ARB_RR_EN
        last_d   = start ? win : last_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                owner_d = win;
                gnt_d   = win ? 2'b10 : 2'b01;
                addr_d  = win_addr;
                wdata_d = win_wdata;
                wr_en_d = win_we;
                rd_en_d = !win_we;
                cnt_d   = '0;
                state_d = win_we ? WRITE : READ_WAIT;
            end
            WRITE: state_d = IDLE;
            READ_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                // valid beats the timeout when both land in the same cycle
                if (bus.RF_RdData_Valid) begin
                    rvalid_d = owner_q ? 2'b10 : 2'b01;
                    rdata0_d = owner_q ? rdata0_q : bus.RF_RdData;
                    rdata1_d = owner_q ? bus.RF_RdData : rdata1_q;
                    state_d  = IDLE;
                end else if (cnt_d == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            err_q    <= err_d;
        end
    end
    assign bus.M0_GNT         = gnt_q[0];
    assign bus.M1_GNT         = gnt_q[1];
    assign bus.M0_RVALID      = rvalid_q[0];
    assign bus.M1_RVALID      = rvalid_q[1];
    assign bus.M0_RDATA       = rdata0_q;
    assign bus.M1_RDATA       = rdata1_q;
    assign bus.RF_RdEn        = rd_en_q;
    assign bus.RF_WrEn        = wr_en_q;
    assign bus.RF_Address     = addr_q;
    assign bus.RF_WrData      = wdata_q;
    assign bus.RD_TIMEOUT_ERR = err_q;
endmodule
